// File: rtl/gpu_axi_mem_slave_if.sv
// AXI4-lite channel subset (AR/R/AW/W/B, no ID/RESP/burst) between GPU bridge and memory slave.
// Latency: none (wires only). Backpressure: valid/ready per channel.
interface gpu_axi_mem_slave_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   s_araddr;
    logic                    s_arvalid;
    logic                    s_arready;
    logic [DATA_WIDTH-1:0]   s_rdata;
    logic                    s_rvalid;
    logic                    s_rready;
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic                    s_awvalid;
    logic                    s_awready;
    logic [DATA_WIDTH-1:0]   s_wdata;
    logic [DATA_WIDTH/8-1:0] s_wstrb;
    logic                    s_wvalid;
    logic                    s_wready;
    logic                    s_bvalid;
    logic                    s_bready;

    modport slave (
        input  s_araddr, s_arvalid, s_rready,
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        output s_arready, s_rdata, s_rvalid, s_awready, s_wready, s_bvalid
    );

    modport master (
        output s_araddr, s_arvalid, s_rready,
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
        input  s_arready, s_rdata, s_rvalid, s_awready, s_wready, s_bvalid
    );
endinterface

// File: rtl/gpu_axi_mem_slave.sv
// AXI4-lite single-beat SRAM responder, independent read/write FSMs, one outstanding per direction.
// Latency: AR->RVALID READ_LAT cycles; last of AW/W -> BVALID 2 cycles.
// Backpressure: R/B held until ready; AR/AW/W readies low while busy (LFSR stalls with GPU_AXI_SLV_STALL_EN).
module gpu_axi_mem_slave #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    DATA_WIDTH  = 32,
    parameter int                    DEPTH_WORDS = 1024,
    parameter int                    READ_LAT    = 2,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0
) (
    input  logic               clk,
    input  logic               rst,
    gpu_axi_mem_slave_if.slave s,
    output logic [15:0]        oob_count
);
    localparam int NB  = DATA_WIDTH / 8;
    localparam int BSH = $clog2(NB);
    localparam int IW  = $clog2(DEPTH_WORDS);
    localparam int CW  = $clog2(READ_LAT + 1);
    localparam logic [CW-1:0] RCNT_INIT = (READ_LAT > 1) ? CW'(READ_LAT - 2) : '0;

    localparam logic [1:0] R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2;
    localparam logic [1:0] W_IDLE = 2'd0, W_COMMIT = 2'd1, W_RESP = 2'd2;

    function automatic logic dec_oob(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ((off >> BSH) >= ADDR_WIDTH'(DEPTH_WORDS));
    endfunction

    function automatic logic [IW-1:0] dec_idx(input logic [ADDR_WIDTH-1:0] a);
        logic [ADDR_WIDTH-1:0] off;
        off = a - BASE_ADDR;
        return IW'(off >> BSH);
    endfunction

    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic                  r_live;
    logic                  w_stall;
    logic [1:0]            r_rstate;
    logic [CW-1:0]         r_rcnt;
    logic [IW-1:0]         r_ridx;
    logic                  r_roob;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_wstate;
    logic                  r_aw_held, r_w_held;
    logic [IW-1:0]         r_widx;
    logic                  r_woob;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [NB-1:0]         r_wstrb;

    logic          w_ar_hs, w_aw_hs, w_w_hs, w_ar_oob, w_aw_oob;
    logic [IW-1:0] w_ar_idx, w_aw_idx, w_rd_idx;
    logic          w_rd_oob, w_rd_load, w_commit;
    logic [1:0]    w_oob_inc;
    logic [16:0]   w_oob_sum;

`ifdef GPU_AXI_SLV_STALL_EN
    logic [7:0] r_lfsr;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lfsr <= 8'hA5;
        else     r_lfsr <= {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
    end
    assign w_stall = r_lfsr[0];
`else
    assign w_stall = 1'b0;
`endif

    // Readies stay low through reset and rise on the first edge after release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_live <= 1'b0;
        else     r_live <= 1'b1;
    end

    assign s.s_arready = r_live && (r_rstate == R_IDLE) && !w_stall;
    assign s.s_awready = r_live && (r_wstate == W_IDLE) && !r_aw_held && !w_stall;
    assign s.s_wready  = r_live && (r_wstate == W_IDLE) && !r_w_held && !w_stall;
    assign s.s_rvalid  = (r_rstate == R_RESP);
    assign s.s_rdata   = r_rdata;
    assign s.s_bvalid  = (r_wstate == W_RESP);

    assign w_ar_hs  = s.s_arvalid && s.s_arready;
    assign w_aw_hs  = s.s_awvalid && s.s_awready;
    assign w_w_hs   = s.s_wvalid && s.s_wready;
    assign w_ar_oob = dec_oob(s.s_araddr);
    assign w_aw_oob = dec_oob(s.s_awaddr);
    assign w_ar_idx = dec_idx(s.s_araddr);
    assign w_aw_idx = dec_idx(s.s_awaddr);

    // With READ_LAT=1 the SRAM is read straight from the AR channel on the handshake edge.
    assign w_rd_idx  = (READ_LAT == 1) ? w_ar_idx : r_ridx;
    assign w_rd_oob  = (READ_LAT == 1) ? w_ar_oob : r_roob;
    assign w_rd_load = ((r_rstate == R_IDLE) && w_ar_hs && (READ_LAT == 1)) ||
                       ((r_rstate == R_WAIT) && (r_rcnt == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rstate <= R_IDLE;
            r_rcnt   <= '0;
            r_ridx   <= '0;
            r_roob   <= 1'b0;
            r_rdata  <= '0;
        end else begin
            if (w_rd_load) r_rdata <= w_rd_oob ? '0 : r_mem[w_rd_idx];
            case (r_rstate)
                R_IDLE: if (w_ar_hs) begin
                    r_ridx   <= w_ar_idx;
                    r_roob   <= w_ar_oob;
                    r_rcnt   <= RCNT_INIT;
                    r_rstate <= (READ_LAT == 1) ? R_RESP : R_WAIT;
                end
                R_WAIT: begin
                    if (r_rcnt == '0) r_rstate <= R_RESP;
                    else              r_rcnt   <= r_rcnt - 1'b1;
                end
                R_RESP:  if (s.s_rready) r_rstate <= R_IDLE;
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wstate  <= W_IDLE;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_widx    <= '0;
            r_woob    <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_widx    <= w_aw_idx;
                        r_woob    <= w_aw_oob;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s.s_wdata;
                        r_wstrb  <= s.s_wstrb;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) r_wstate <= W_COMMIT;
                end
                W_COMMIT: begin
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_wstate  <= W_RESP;
                end
                W_RESP:  if (s.s_bready) r_wstate <= W_IDLE;
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // SRAM is not reset; an in-flight commit is cancelled by reset via the state clear.
    assign w_commit = !rst && (r_wstate == W_COMMIT) && !r_woob;

    always_ff @(posedge clk) begin
        if (w_commit) begin
            for (int i = 0; i < NB; i++) begin
                if (r_wstrb[i]) r_mem[r_widx][8*i +: 8] <= r_wdata[8*i +: 8];
            end
        end
    end

    assign w_oob_inc = {1'b0, w_ar_hs && w_ar_oob} + {1'b0, w_aw_hs && w_aw_oob};
    assign w_oob_sum = {1'b0, oob_count} + 17'(w_oob_inc);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) oob_count <= '0;
        else     oob_count <= w_oob_sum[16] ? 16'hFFFF : w_oob_sum[15:0];
    end
endmodule

// File: tb/tb_gpu_axi_mem_slave.sv
// Randomized self-checking bench for gpu_axi_mem_slave against a word-array reference model.
// Latency: checks READ_LAT and 2-cycle B response. Backpressure: exercises R/B ready stalls.
module tb_gpu_axi_mem_slave;
    localparam int RL    = 2;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] oob_count;

    always #5 clk = ~clk;

    gpu_axi_mem_slave_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    gpu_axi_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_WORDS(DEPTH),
        .READ_LAT(RL), .BASE_ADDR(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .s(bus), .oob_count(oob_count)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] mdl_mem [int];
    int          mdl_oob = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic bit mdl_is_oob(input logic [31:0] a);
        return (a / 4) >= DEPTH;
    endfunction

    function automatic void mdl_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st);
        logic [31:0] w;
        int          idx;
        if (mdl_is_oob(a)) return;
        idx = int'(a / 4);
        w = mdl_mem.exists(idx) ? mdl_mem[idx] : 32'h0;
        for (int b = 0; b < 4; b++)
            if (st[b]) w[8*b +: 8] = d[8*b +: 8];
        mdl_mem[idx] = w;
    endfunction

    function automatic logic [31:0] mdl_read(input logic [31:0] a);
        if (mdl_is_oob(a)) return 32'h0;
        return mdl_mem[int'(a / 4)];
    endfunction

    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int lead, input string tag);
        int g, lat;
        bit aw_d, w_d, aw_h, w_h, drop_seen;
        aw_d = 0; w_d = 0; g = 0; drop_seen = 0;
        bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = st;
        bus.s_wvalid = 1'b1; bus.s_awvalid = (lead == 0);
        while (!(aw_d && w_d) && g < 100) begin
            aw_h = bus.s_awvalid && bus.s_awready;
            w_h  = bus.s_wvalid && bus.s_wready;
            tick; g++;
            if (aw_h) begin aw_d = 1; bus.s_awvalid = 1'b0; end
            if (w_h)  begin w_d = 1;  bus.s_wvalid  = 1'b0; end
            if (w_d && !aw_d && !drop_seen) begin
                chk({tag, "_wready_drop"}, 32'(bus.s_wready), 32'd0);
                drop_seen = 1;
            end
            if (!aw_d && g >= lead) bus.s_awvalid = 1'b1;
        end
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        chk({tag, "_handshake"}, 32'(aw_d && w_d), 32'd1);
        mdl_write(a, d, st);
        if (mdl_is_oob(a)) mdl_oob++;
        lat = 1;
        while (!bus.s_bvalid && lat < 50) begin tick; lat++; end
        chk({tag, "_b_latency"}, 32'(lat), 32'd2);
        bus.s_bready = 1'b1; tick; bus.s_bready = 1'b0;
        chk({tag, "_bvalid_clear"}, 32'(bus.s_bvalid), 32'd0);
        chk({tag, "_oob_count"}, 32'(oob_count), 32'(mdl_oob));
    endtask

    task automatic axi_read(input logic [31:0] a, input int bp, input string tag, output logic [31:0] rd);
        int g, lat;
        logic [31:0] exp;
        exp = mdl_read(a);
        bus.s_araddr = a; bus.s_arvalid = 1'b1; g = 0;
        while (!bus.s_arready && g < 100) begin tick; g++; end
        chk({tag, "_ar_ready"}, 32'(bus.s_arready), 32'd1);
        tick; bus.s_arvalid = 1'b0; lat = 1;
        if (mdl_is_oob(a)) mdl_oob++;
        chk({tag, "_arready_busy"}, 32'(bus.s_arready), 32'd0);
        while (!bus.s_rvalid && lat < 50) begin tick; lat++; end
        chk({tag, "_r_latency"}, 32'(lat), 32'(RL));
        chk({tag, "_rdata"}, bus.s_rdata, exp);
        for (int i = 0; i < bp; i++) begin
            tick;
            chk({tag, "_bp_rvalid"}, 32'(bus.s_rvalid), 32'd1);
            chk({tag, "_bp_rdata"}, bus.s_rdata, exp);
            chk({tag, "_bp_arready"}, 32'(bus.s_arready), 32'd0);
        end
        rd = bus.s_rdata;
        bus.s_rready = 1'b1; tick; bus.s_rready = 1'b0;
        chk({tag, "_rvalid_clear"}, 32'(bus.s_rvalid), 32'd0);
`ifndef GPU_AXI_SLV_STALL_EN
        chk({tag, "_arready_back"}, 32'(bus.s_arready), 32'd1);
`endif
        chk({tag, "_oob_count"}, 32'(oob_count), 32'(mdl_oob));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, a;
        int          g, r;
        bus.s_araddr = '0; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
        bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0;
        bus.s_wstrb = '0;  bus.s_wvalid = 1'b0;  bus.s_bready = 1'b0;

        repeat (3) tick;
        chk("rst_arready", 32'(bus.s_arready), 32'd0);
        chk("rst_awready", 32'(bus.s_awready), 32'd0);
        chk("rst_wready",  32'(bus.s_wready),  32'd0);
        chk("rst_rvalid",  32'(bus.s_rvalid),  32'd0);
        chk("rst_bvalid",  32'(bus.s_bvalid),  32'd0);
        chk("rst_rdata",   bus.s_rdata,        32'd0);
        chk("rst_oob",     32'(oob_count),     32'd0);
        rst = 1'b0;
        tick;
`ifndef GPU_AXI_SLV_STALL_EN
        chk("post_rst_arready", 32'(bus.s_arready), 32'd1);
        chk("post_rst_awready", 32'(bus.s_awready), 32'd1);
        chk("post_rst_wready",  32'(bus.s_wready),  32'd1);
`endif

        axi_write(32'h10, 32'hCAFEBABE, 4'hF, 0, "full_wr");
        axi_read(32'h10, 0, "full_rd", rd);
        chk("full_const", rd, 32'hCAFEBABE);

        axi_write(32'h20, 32'h11223344, 4'hF, 0, "strb_wr1");
        axi_write(32'h20, 32'hAABBCCDD, 4'h5, 0, "strb_wr2");
        axi_read(32'h20, 0, "strb_rd", rd);
        chk("strb_const", rd, 32'h11BB33DD);

        axi_write(32'h30, 32'h5A5AC3C3, 4'hF, 3, "wfirst_wr");
        axi_read(32'h30, 0, "wfirst_rd", rd);
        axi_read(32'h10, 5, "bp", rd);

        axi_write(32'h0, 32'h0BADF00D, 4'hF, 0, "w0_wr");
        for (int k = 0; k < 16; k++)
            axi_write(32'h100 + 32'(k * 4), $urandom, 4'hF, 0, "init_wr");

        axi_read(32'h1000, 0, "oob_rd", rd);
        chk("oob_rd_const", rd, 32'h0);
        chk("oob_cnt_const", 32'(oob_count), 32'd1);
        axi_write(32'h1000, 32'hDEADBEEF, 4'hF, 0, "oob_wr");
        axi_read(32'h0, 0, "oob_w0_rd", rd);
        chk("oob_w0_const", rd, 32'h0BADF00D);

        // Simultaneous out-of-range AR and AW handshakes must add two.
        bus.s_araddr = 32'h2000; bus.s_awaddr = 32'h2004; bus.s_wdata = 32'h1; bus.s_wstrb = 4'hF;
        bus.s_arvalid = 1'b1; bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; g = 0;
        while (!(bus.s_arready && bus.s_awready && bus.s_wready) && g < 100) begin tick; g++; end
        tick;
        bus.s_arvalid = 1'b0; bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        mdl_oob += 2;
        chk("dual_oob_count", 32'(oob_count), 32'(mdl_oob));
        bus.s_rready = 1'b1; bus.s_bready = 1'b1;
        repeat (4) tick;
        bus.s_rready = 1'b0; bus.s_bready = 1'b0;
        chk("dual_idle", 32'(bus.s_rvalid || bus.s_bvalid), 32'd0);

        // Reset during W_COMMIT: the write must not land.
        bus.s_awaddr = 32'h100; bus.s_wdata = 32'hFFFFFFFF; bus.s_wstrb = 4'hF;
        bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1; g = 0;
        while (!(bus.s_awready && bus.s_wready) && g < 100) begin tick; g++; end
        tick;
        bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
        rst = 1'b1; #1;
        chk("rstw_bvalid", 32'(bus.s_bvalid), 32'd0);
        tick; tick;
        rst = 1'b0; mdl_oob = 0;
        tick;
        axi_read(32'h100, 0, "rstw_rd", rd);

        // Reset while the read waits in R_WAIT.
        bus.s_araddr = 32'h10; bus.s_arvalid = 1'b1; g = 0;
        while (!bus.s_arready && g < 100) begin tick; g++; end
        tick;
        bus.s_arvalid = 1'b0;
        rst = 1'b1; #1;
        chk("rstr_rvalid", 32'(bus.s_rvalid), 32'd0);
        chk("rstr_arready", 32'(bus.s_arready), 32'd0);
        tick; tick;
        rst = 1'b0;
        chk("rstr_oob_clear", 32'(oob_count), 32'd0);
        tick;
`ifndef GPU_AXI_SLV_STALL_EN
        chk("rstr_arready_back", 32'(bus.s_arready), 32'd1);
`endif
        bus.s_rready = 1'b1;
        repeat (3) begin
            tick;
            chk("rstr_no_resp", 32'(bus.s_rvalid), 32'd0);
        end
        bus.s_rready = 1'b0;
        axi_read(32'h10, 0, "rstr_keep", rd);
        chk("rstr_keep_const", rd, 32'hCAFEBABE);

        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) a = 32'h1000 + 32'($urandom_range(0, 255) * 4);
            else        a = 32'h100 + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1)
                axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3), "rnd_wr");
            else
                axi_read(a, $urandom_range(0, 3), "rnd_rd", rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/gpu_axi_mem_slave.md
# gpu_axi_mem_slave

AXI4-lite single-beat responder backed by a word-addressed on-chip SRAM. It is the memory-side endpoint for the mini-GPU AXI master bridge in unit and integration benches, and a small local scratch memory in the GPU subsystem. It uses the same channel subset as the master: no ID, no RRESP/BRESP, no burst. Reads and writes are handled by independent state machines, with one outstanding transaction per direction.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, data width; must be a power of two and at least 8
- DEPTH_WORDS, 1024, SRAM depth in DATA_WIDTH words; must be a power of two
- READ_LAT, 2, cycles from AR handshake to RVALID; must be at least 1
- BASE_ADDR, 0, byte address of word 0

Ports:
- clk  in  1  clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- s_araddr  in  ADDR_WIDTH  read address
- s_arvalid  in  1  read address valid
- s_arready  out  1  read address ready
- s_rdata  out  DATA_WIDTH  read data
- s_rvalid  out  1  read data valid
- s_rready  in  1  read data ready
- s_awaddr  in  ADDR_WIDTH  write address
- s_awvalid  in  1  write address valid
- s_awready  out  1  write address ready
- s_wdata  in  DATA_WIDTH  write data
- s_wstrb  in  DATA_WIDTH/8  byte strobes
- s_wvalid  in  1  write data valid
- s_wready  out  1  write data ready
- s_bvalid  out  1  write response valid
- s_bready  in  1  write response ready
- oob_count  out  16  saturating count of out-of-range accesses

## Operation
- Address decode:
  - offset = addr − BASE_ADDR.
  - Word index = offset >> log2(DATA_WIDTH/8); the low byte-offset bits are ignored.
  - An access is out-of-range when addr < BASE_ADDR or word index ≥ DEPTH_WORDS.
- Read FSM: R_IDLE → R_WAIT → R_RESP.
  - R_IDLE: s_arready=1. An AR handshake captures the address.
  - R_WAIT: counts READ_LAT−1 cycles. When READ_LAT=1, the FSM goes directly to R_RESP.
  - On entry to R_RESP, s_rdata is registered from the SRAM. Out-of-range reads return 0.
  - R_RESP: s_rvalid=1, with s_rdata stable until the R handshake. The FSM then returns to R_IDLE.
- Write FSM: W_IDLE → W_COMMIT → W_RESP.
  - In W_IDLE, AW and W are accepted independently, in either order or together.
  - s_awready=1 until AW is captured; s_wready=1 until W is captured.
  - Once both are held, the FSM goes to W_COMMIT, which writes bytes with s_wstrb[i]=1 in one cycle. Out-of-range writes are dropped.
  - W_RESP: s_bvalid=1 until the B handshake, then the FSM returns to W_IDLE with both readies high.
- oob_count increments by 1 per out-of-range AR or AW handshake and saturates at 0xFFFF.
- A read and a write in the same cycle count as +2.

## Timing
- Reset values:
  - All ready and valid outputs 0; s_rdata 0; oob_count 0; both FSMs idle.
  - Readies rise the first cycle after rst deasserts.
  - SRAM contents are not reset.
- Read latency: AR handshake in cycle T gives s_rvalid=1 in cycle T+READ_LAT. s_arready is 0 from T+1 until the cycle after the R handshake.
- Write latency: with the later of AW/W accepted in cycle T, W_COMMIT is in T+1 and s_bvalid=1 in T+2.
- Read and write collision: a W_COMMIT and an R_RESP entry to the same word on the same edge return the old data (read-before-write).
- The two directions never stall each other.
- Reset mid-operation: any in-flight read or write is abandoned and its response is never issued. A W_COMMIT not yet executed does not write. SRAM contents are retained.

## Configuration
- GPU_AXI_SLV_STALL_EN defined:
  - An 8-bit Fibonacci LFSR (taps 8,6,5,4; seed 0xA5 at reset) advances every cycle.
  - When lfsr[0]=1, s_arready, s_awready and s_wready are forced 0 that cycle.
  - Valid outputs are unaffected.
- Not defined: readies follow the FSMs only. No LFSR logic is present.

## Test plan
- Full write then read: write 0xCAFEBABE to 0x10 with wstrb 0xF, then read 0x10.
  - s_bvalid two cycles after the AW/W handshake.
  - s_rdata=0xCAFEBABE exactly READ_LAT cycles after AR.
- Byte strobes: write 0x11223344, then write 0xAABBCCDD with wstrb 0x5 to the same address, then read it.
  - Read returns 0x11BB33DD.
- W before AW: W presented 3 cycles before AW.
  - s_wready drops after W is captured.
  - s_bvalid follows the AW handshake by 2 cycles.
  - Stored data is correct.
- R backpressure: hold s_rready=0 for 5 cycles.
  - s_rvalid and s_rdata stay stable.
  - s_arready stays 0 until the cycle after the handshake.
- Out-of-range: read BASE_ADDR+DEPTH_WORDS*4.
  - Returns 0; oob_count=1.
  - A write to the same address is dropped; a read of word 0 is unchanged.
- Reset mid-read: assert rst during R_WAIT.
  - s_rvalid=0 immediately.
  - s_arready=1 one cycle after release.
  - Earlier writes still read back.
